// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, frame width
// and the legal ranges of the timing parameters.
package spi_pkg;

    localparam int unsigned SPI_BITS     = 8;
    localparam int unsigned SPI_BIT_W    = $clog2(SPI_BITS);
    localparam logic [SPI_BIT_W-1:0] SPI_BIT_LAST = SPI_BIT_W'(SPI_BITS - 1);

    // CLK_DIV and CS_SETUP lower bounds leave room for the slave's
    // 3-flop input synchroniser to settle before each sampling edge.
    localparam int unsigned CLK_DIV_MIN  = 4;
    localparam int unsigned CLK_DIV_MAX  = 255;
    localparam int unsigned CS_SETUP_MIN = 4;
    localparam int unsigned CS_SETUP_MAX = 255;
    localparam int unsigned CS_HOLD_MIN  = 1;
    localparam int unsigned CS_HOLD_MAX  = 255;
    localparam int unsigned CS_IDLE_MIN  = 1;
    localparam int unsigned CS_IDLE_MAX  = 255;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        WAIT,
        GAP
    } state_e;

    function automatic bit in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator for the SPI master.
//   clk, rst      : system clock, synchronous active-low reset
//   en_i          : run the generator; when low all state returns to zero
//   sck_o         : registered serial clock, idles low
//   sck_rise_o    : SCK goes high at the coming clk edge
//   sck_fall_o    : SCK goes low at the coming clk edge
//   bit_idx_o     : index of the bit currently on the wire (0 = MSB)
//   byte_done_o   : the coming fall is the last one of the frame
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    output logic                 sck_o,
    output logic                 sck_rise_o,
    output logic                 sck_fall_o,
    output logic [SPI_BIT_W-1:0] bit_idx_o,
    output logic                 byte_done_o
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic [7:0]           half_q, half_d;
    logic                 phase_q, phase_d;
    logic [SPI_BIT_W-1:0] bit_q, bit_d;
    logic                 half_end;

    assign half_end    = en_i && (half_q == HALF_LAST);
    assign sck_rise_o  = half_end && !phase_q;
    assign sck_fall_o  = half_end && phase_q;
    assign byte_done_o = sck_fall_o && (bit_q == SPI_BIT_LAST);
    assign sck_o       = phase_q;
    assign bit_idx_o   = bit_q;

    always_comb begin
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        if (!en_i) begin
            half_d  = '0;
            phase_d = 1'b0;
            bit_d   = '0;
        end else if (half_end) begin
            half_d  = '0;
            phase_d = !phase_q;
            // Bit index wraps to 0 on the final fall, ready for a WAIT restart.
            if (phase_q) begin
                bit_d = bit_q + 1'b1;
            end
        end else begin
            half_d = half_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            half_q  <= half_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 8-bit frames.
//   clk, rst             : system clock, synchronous active-low reset
//   tx_data/tx_last      : byte to send; tx_last closes the SSEL frame after it
//   tx_valid/tx_ready    : byte handshake, accepted when both are high
//   rx_data/rx_stb       : received byte and its one-cycle strobe
//   busy                 : high whenever the FSM is not idle
//   SCK/MOSI/SSEL/MISO   : serial pins (all outputs registered)
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_last,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_stb,
    output logic                busy,
    output logic                SCK,
    output logic                MOSI,
    output logic                SSEL,
    input  logic                MISO
);

    if (!in_range(CLK_DIV, CLK_DIV_MIN, CLK_DIV_MAX) ||
        !in_range(CS_SETUP, CS_SETUP_MIN, CS_SETUP_MAX) ||
        !in_range(CS_HOLD, CS_HOLD_MIN, CS_HOLD_MAX) ||
        !in_range(CS_IDLE, CS_IDLE_MIN, CS_IDLE_MAX)) begin : g_param_err
        $error("spi_master: timing parameter out of range");
    end

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SPI_BITS-1:0]  tx_sh_q, tx_sh_d;
    logic [SPI_BITS-1:0]  rx_sh_q, rx_sh_d;
    logic [SPI_BITS-1:0]  rx_data_q, rx_data_d;
    logic                 last_q, last_d;
    logic                 mosi_q, mosi_d;
    logic                 ssel_q, ssel_d;
    logic                 rx_stb_q, rx_stb_d;
    logic                 miso_meta_q, miso_sync_q;

    logic                 accept;
    logic                 sck_rise, sck_fall, byte_done;
    logic [SPI_BIT_W-1:0] bit_idx;
    logic [SPI_BITS-1:0]  rx_shifted;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == XFER),
        .sck_o       (SCK),
        .sck_rise_o  (sck_rise),
        .sck_fall_o  (sck_fall),
        .bit_idx_o   (bit_idx),
        .byte_done_o (byte_done)
    );

    assign tx_ready   = rst && ((state_q == IDLE) || (state_q == WAIT));
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state_q != IDLE);
    assign rx_shifted = {rx_sh_q[SPI_BITS-2:0], miso_sync_q};

    assign SSEL    = ssel_q;
    assign MOSI    = mosi_q;
    assign rx_data = rx_data_q;
    assign rx_stb  = rx_stb_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        last_d    = last_q;
        mosi_d    = mosi_q;
        ssel_d    = ssel_q;
        rx_stb_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[SPI_BITS-1];
                    ssel_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            XFER: begin
                if (sck_rise) begin
                    rx_sh_d = rx_shifted;
                    if (bit_idx == SPI_BIT_LAST) begin
                        rx_data_d = rx_shifted;
                        rx_stb_d  = 1'b1;
                    end
                end
                // MOSI keeps the final bit after the last fall.
                if (byte_done) begin
                    cnt_d   = '0;
                    state_d = last_q ? HOLD : WAIT;
                end else if (sck_fall) begin
                    mosi_d  = tx_sh_q[SPI_BITS-2];
                    tx_sh_d = {tx_sh_q[SPI_BITS-2:0], 1'b0};
                end
            end
            WAIT: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[SPI_BITS-1];
                    state_d = XFER;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    ssel_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            last_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ssel_q      <= 1'b1;
            rx_stb_q    <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            last_q      <= last_d;
            mosi_q      <= mosi_d;
            ssel_q      <= ssel_d;
            rx_stb_q    <= rx_stb_d;
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a default-timing instance (loopback or modelled
// slave on MISO) and a CLK_DIV=7 / CS_SETUP=9 instance for phase timing.
module tb_spi_master;

    localparam int unsigned DIV  = 4;
    localparam int unsigned SET  = 4;
    localparam int unsigned HLD  = 4;
    localparam int unsigned IDL  = 4;
    localparam int unsigned DIV2 = 7;
    localparam int unsigned SET2 = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT 1 (default timing) ----------------
    logic [7:0] tx_data = '0;
    logic       tx_last = 1'b0, tx_valid = 1'b0;
    logic       tx_ready, rx_stb, busy, sck, mosi, ssel;
    logic [7:0] rx_data;
    logic       loop = 1'b1, slave_bit = 1'b0, miso;
    assign miso = loop ? mosi : slave_bit;

    spi_master u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_stb(rx_stb), .busy(busy), .SCK(sck), .MOSI(mosi), .SSEL(ssel),
        .MISO(miso)
    );

    // ---------------- DUT 2 (slow SCK, long setup) ----------------
    logic [7:0] tx_data2 = '0;
    logic       tx_last2 = 1'b0, tx_valid2 = 1'b0;
    logic       tx_ready2, rx_stb2, busy2, sck2, mosi2, ssel2;
    logic [7:0] rx_data2;

    spi_master #(.CLK_DIV(DIV2), .CS_SETUP(SET2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_last(tx_last2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .rx_data(rx_data2),
        .rx_stb(rx_stb2), .busy(busy2), .SCK(sck2), .MOSI(mosi2), .SSEL(ssel2),
        .MISO(mosi2)
    );

    // ---------------- wire-level observer for DUT 1 ----------------
    int         rises = 0, ssel_falls = 0, stb_cnt = 0;
    int         low_run = 0, last_low_len = 0, hi_run = 0, gap_len = 0;
    logic       p_sck = 1'b0, p_ssel = 1'b1, p_ready = 1'b0;
    logic [7:0] mosi_bits = '0, rbyte;
    logic [7:0] rx_q[$], mosi_q[$];
    logic [7:0] resp_arr[16];

    always @(negedge clk) begin
        if (sck === 1'b1 && p_sck === 1'b0) begin
            mosi_bits = {mosi_bits[6:0], mosi};
            rises++;
            if (rises % 8 == 0) mosi_q.push_back(mosi_bits);
        end
        if (rx_stb === 1'b1) begin
            rx_q.push_back(rx_data);
            stb_cnt++;
        end
        if (ssel === 1'b0 && p_ssel === 1'b1) begin
            ssel_falls++;
            low_run = 0;
        end
        if (ssel === 1'b0) low_run++;
        if (ssel === 1'b1 && p_ssel === 1'b0) last_low_len = low_run;
        hi_run = (ssel === 1'b1) ? hi_run + 1 : 0;
        if (tx_ready === 1'b1 && p_ready === 1'b0 && ssel === 1'b1) gap_len = hi_run - 1;
        // Modelled slave: presents resp_arr[k] MSB first, advancing after each rise.
        rbyte     = resp_arr[(rises / 8) % 16];
        slave_bit = rbyte[7 - (rises % 8)];
        p_sck   = sck;
        p_ssel  = ssel;
        p_ready = tx_ready;
    end

    // ---------------- phase-length observer for DUT 2 ----------------
    int         cyc2 = 0, fall_t2 = 0, first_dist2 = -1, low2_run = 0, low2_len = 0, run2 = 0;
    bit         seen_rise2 = 1'b0;
    int         hi_runs2[$], lo_runs2[$];
    logic       p_sck2 = 1'b0, p_ssel2 = 1'b1;
    logic [7:0] rx2_q[$];

    always @(negedge clk) begin
        cyc2++;
        if (ssel2 === 1'b0 && p_ssel2 === 1'b1) begin
            fall_t2    = cyc2;
            seen_rise2 = 1'b0;
            low2_run   = 0;
        end
        if (ssel2 === 1'b0) low2_run++;
        if (ssel2 === 1'b1 && p_ssel2 === 1'b0) low2_len = low2_run;
        if (sck2 !== p_sck2) begin
            if (sck2 === 1'b1) begin
                if (!seen_rise2) begin
                    first_dist2 = cyc2 - fall_t2;
                    seen_rise2  = 1'b1;
                end else begin
                    lo_runs2.push_back(run2);
                end
            end else if (p_sck2 === 1'b1) begin
                hi_runs2.push_back(run2);
            end
            run2 = 1;
        end else begin
            run2++;
        end
        if (rx_stb2 === 1'b1) rx2_q.push_back(rx_data2);
        p_sck2  = sck2;
        p_ssel2 = ssel2;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rises      = 0;
        ssel_falls = 0;
        stb_cnt    = 0;
        mosi_bits  = '0;
        rx_q.delete();
        mosi_q.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        tx_valid = 1'b0;
        check("send_timeout", (n >= 3000), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            tick();
            n++;
        end
        tick();
        check("idle_timeout", (n >= 5000), 0);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] sent[16];
    logic [7:0] exp_q[$];
    int         nb, n, bad, acc;
    logic [7:0] d2;

    initial begin
        for (int i = 0; i < 16; i++) resp_arr[i] = '0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_ssel", ssel, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_stb", rx_stb, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ssel2", ssel2, 1);
        rst = 1'b1;
        tick();
        check("ready_after_rst", tx_ready, 1);

        // Loopback single byte 0xA5
        clr();
        loop = 1'b1;
        send(8'hA5, 1'b1);
        wait_idle();
        check("a5_rises", rises, 8);
        check("a5_mosi", (mosi_q.size() == 1) ? mosi_q[0] : 8'hxx, 8'hA5);
        check("a5_stb_cnt", stb_cnt, 1);
        check("a5_rx", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'hA5);
        check("a5_ssel_low", last_low_len, SET + 16 * DIV + HLD);
        check("a5_gap", gap_len, IDL);
        check("a5_rx_held", rx_data, 8'hA5);

        // Random multi-byte frames against a modelled slave
        for (int rep = 0; rep < 2; rep++) begin
            clr();
            loop = 1'b0;
            nb = 2 + int'($urandom % 3);
            for (int k = 0; k < nb; k++) begin
                resp_arr[k] = 8'($urandom);
                sent[k]     = 8'($urandom);
            end
            tick();
            for (int k = 0; k < nb; k++) send(sent[k], (k == nb - 1));
            wait_idle();
            check("multi_nbytes", rx_q.size(), nb);
            check("multi_rises", rises, 8 * nb);
            check("multi_one_frame", ssel_falls, 1);
            for (int k = 0; k < nb; k++) begin
                check("multi_rx", (k < rx_q.size()) ? rx_q[k] : 8'hxx, resp_arr[k]);
                check("multi_mosi", (k < mosi_q.size()) ? mosi_q[k] : 8'hxx, sent[k]);
            end
        end

        // WAIT stall
        clr();
        loop = 1'b1;
        send(8'h81, 1'b0);
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("wait_reach_timeout", (n >= 2000), 0);
        bad = 0;
        repeat (200) begin
            tick();
            if (ssel !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("wait_stall_bad_cycles", bad, 0);
        send(8'h7E, 1'b1);
        wait_idle();
        check("wait_nbytes", rx_q.size(), 2);
        check("wait_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h81);
        check("wait_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h7E);
        check("wait_one_frame", ssel_falls, 1);

        // Reset mid-byte
        clr();
        send(8'hFF, 1'b1);
        n = 0;
        while (rises < 3 && n < 2000) begin
            tick();
            n++;
        end
        check("midrst_reach_timeout", (n >= 2000), 0);
        rst = 1'b0;
        tick();
        check("midrst_ssel", ssel, 1);
        check("midrst_sck", sck, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_rx_stb", rx_stb, 0);
        check("midrst_busy", busy, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_no_stb", stb_cnt, 0);
        clr();
        send(8'hFF, 1'b1);
        wait_idle();
        check("midrst_fresh_rx", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'hFF);

        // Slow-SCK instance: phase lengths and first-rise distance
        hi_runs2.delete();
        lo_runs2.delete();
        rx2_q.delete();
        d2        = 8'($urandom);
        tx_data2  = d2;
        tx_last2  = 1'b1;
        tx_valid2 = 1'b1;
        n = 0;
        while (tx_ready2 !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tx_valid2 = 1'b0;
        while (busy2 !== 1'b0 && n < 4000) begin
            tick();
            n++;
        end
        tick();
        check("div7_timeout", (n >= 4000), 0);
        check("div7_first_rise", first_dist2, SET2 + DIV2);
        check("div7_high_count", hi_runs2.size(), 8);
        check("div7_low_count", lo_runs2.size(), 7);
        bad = 0;
        foreach (hi_runs2[i]) if (hi_runs2[i] != DIV2) bad++;
        foreach (lo_runs2[i]) if (lo_runs2[i] != DIV2) bad++;
        check("div7_phase_len", bad, 0);
        check("div7_ssel_low", low2_len, SET2 + 16 * DIV2 + HLD);
        check("div7_rx", (rx2_q.size() == 1) ? rx2_q[0] : 8'hxx, d2);

        // Backpressure: tx_valid held high with last=1
        clr();
        loop = 1'b1;
        exp_q.delete();
        tx_last  = 1'b1;
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        acc = 0;
        bad = 0;
        n = 0;
        while (acc < 3 && n < 3000) begin
            if (tx_ready === 1'b1 && busy === 1'b1) bad++;
            if (tx_ready === 1'b1) begin
                exp_q.push_back(tx_data);
                acc++;
                tick();
                tx_data = 8'($urandom);
                if (acc == 3) tx_valid = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        tx_valid = 1'b0;
        wait_idle();
        check("bp_accepts", acc, 3);
        check("bp_ready_while_busy", bad, 0);
        check("bp_frames", ssel_falls, 3);
        check("bp_stb_cnt", stb_cnt, 3);
        for (int k = 0; k < 3; k++) begin
            check("bp_rx", (k < rx_q.size() && k < exp_q.size()) ? rx_q[k] : 8'hxx,
                  (k < exp_q.size()) ? exp_q[k] : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
